ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Two-port arbiter in front of the single-port 4096x8 synchronous RAM.
- Port A is the CPU and port B is the boot loader / DMA. Both share one RAM address, data and write-enable bus.
- Serialises requests with a req/ack handshake, drives the RAM, and returns read data with a valid strobe to the winning port.
- RAM timing it serves: write when we=1 at the clock edge; otherwise data_out is registered from store[addr] at the edge, one-cycle read latency.

Parameters:
- ADDR_WIDTH, 12, RAM address width.
- DATA_WIDTH, 8, RAM data width.
- FIXED_PRIO, 0, 0 = round-robin between A and B; 1 = port A always wins ties.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset_n  input  1  asynchronous active-low reset.
- a_req  input  1  port A request, held until a_ack.
- a_we  input  1  port A write (1) / read (0).
- a_addr  input  ADDR_WIDTH  port A address.
- a_wdata  input  DATA_WIDTH  port A write data.
- a_ack  output  1  one-cycle pulse: port A request accepted and driven to RAM.
- a_rdata  output  DATA_WIDTH  port A read data.
- a_rvalid  output  1  one-cycle pulse: a_rdata valid.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata, b_rvalid: same as port A, for port B.
- ram_addr  output  ADDR_WIDTH  to RAM addr.
- ram_data_in  output  DATA_WIDTH  to RAM data_in.
- ram_we  output  1  to RAM we.
- ram_data_out  input  DATA_WIDTH  from RAM data_out.

Behaviour:
- Reset (async, reset_n=0):
  - State IDLE; all outputs 0.
  - last_grant = B, so A wins the first tie.
  - Any in-flight transaction is discarded: no ack, no rvalid.
  - After reset release, ram_we stays 0 until a write reaches ACCESS.
- FSM states: IDLE, ACCESS, READ_WAIT.
- IDLE:
  - Samples a_req/b_req each cycle. If neither is asserted, stay; ram_we=0 and ram_addr holds its last value.
  - Single requester: grant it.
  - Both: if FIXED_PRIO=1 grant A; otherwise grant the port not equal to last_grant.
  - On grant: register addr, wdata, we and port id; update last_grant; go to ACCESS.
- ACCESS (one cycle):
  - ram_addr, ram_data_in and ram_we are driven from the latched request. ram_we=1 only for writes.
  - The granted port's ack is 1 this cycle only.
  - Write: go to IDLE. Read: go to READ_WAIT.
- READ_WAIT (one cycle):
  - ram_we=0 and ram_data_out is valid.
  - Capture ram_data_out into the granted port's rdata register; go to IDLE.
  - That port's rvalid = 1 in the following cycle, concurrent with IDLE arbitration.
- Latency, with req first sampled in cycle 0:
  - ack in cycle 1.
  - Write lands at the end of cycle 1.
  - rvalid and rdata in cycle 3.
- Throughput:
  - Writes: one per 2 cycles.
  - Reads: one per 3 cycles.
- Requester rules:
  - Hold req, we, addr and wdata stable until ack; they are not sampled outside IDLE.
  - Requests still asserted in the IDLE cycle after ack are treated as new requests. This gives back-to-back operation with alternation under round-robin.
  - A req dropped before grant is ignored. Once granted, the transaction completes even if req falls.
- a_rdata/b_rdata hold their last captured value until the next read for that port. The non-granted port's rdata never changes.
- No combinational path from any req input to any output; all outputs are registered.
- Only one port's ack or rvalid is ever high in a given cycle.

Test Plan:
- Reset: hold reset_n=0 mid-read (state READ_WAIT) -> all outputs 0 immediately; after release no rvalid; the next A read of 0x000 returns the correct data.
- Single write/read: A writes 0x5A to 0x123, then reads 0x123 -> a_ack in cycles 1 and 4; ram_we=1 only in cycle 1; a_rvalid in cycle 6 with a_rdata=0x5A.
- Simultaneous requests (FIXED_PRIO=0): A and B both hold read requests (A to 0x010, B to 0x020) continuously after reset -> grant order A, B, A, B; acks never overlap; each rvalid carries the correct port's data.
- Fixed priority (FIXED_PRIO=1): A holds req continuously, B requests -> B never acked while A requests; B acked the first IDLE cycle A is low.
- Cross-port coherence: B writes 0xC3 to 0xFFF (address wrap boundary) while A reads 0xFFF queued behind it -> A's read returns 0xC3; no write to 0x000.
- Request withdrawal: B asserts req for one cycle while the arbiter is in ACCESS for A, then drops it -> no b_ack and no RAM access for B.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port req/ack arbiter in front of a single-port synchronous RAM.
// Port A (CPU) and port B (boot loader / DMA) share one RAM bus. Every output is
// a flop, so no req input reaches an output combinationally.
module ram_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int FIXED_PRIO = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_ack,
    output logic [DATA_WIDTH-1:0] a_rdata,
    output logic                  a_rvalid,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_ack,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  b_rvalid,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        READ_WAIT
    } state_t;

    typedef enum logic {
        PORT_A,
        PORT_B
    } port_t;

    state_t state;
    port_t  last_grant;
    port_t  gnt_port;
    logic   lat_we;

    logic   grant_a;
    logic   grant_b;

    // Arbitration decision for the current IDLE cycle: A wins unless B is the
    // sole requester or round-robin says it is B's turn.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (a_req && b_req) begin
            if (FIXED_PRIO != 0 || last_grant == PORT_B) begin
                grant_a = 1'b1;
            end else begin
                grant_b = 1'b1;
            end
        end else begin
            grant_a = a_req;
            grant_b = b_req;
        end
    end

    // Single FSM: grant in IDLE, drive the RAM and ack in ACCESS, capture read
    // data in READ_WAIT. Request fields are latched straight into the RAM bus
    // registers, which then double as the held request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            last_grant  <= PORT_B;
            gnt_port    <= PORT_A;
            lat_we      <= 1'b0;
            ram_addr    <= '0;
            ram_data_in <= '0;
            ram_we      <= 1'b0;
            a_ack       <= 1'b0;
            b_ack       <= 1'b0;
            a_rvalid    <= 1'b0;
            b_rvalid    <= 1'b0;
            a_rdata     <= '0;
            b_rdata     <= '0;
        end else begin
            a_ack    <= 1'b0;
            b_ack    <= 1'b0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            ram_we   <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_a) begin
                        gnt_port    <= PORT_A;
                        last_grant  <= PORT_A;
                        ram_addr    <= a_addr;
                        ram_data_in <= a_wdata;
                        ram_we      <= a_we;
                        lat_we      <= a_we;
                        a_ack       <= 1'b1;
                        state       <= ACCESS;
                    end else if (grant_b) begin
                        gnt_port    <= PORT_B;
                        last_grant  <= PORT_B;
                        ram_addr    <= b_addr;
                        ram_data_in <= b_wdata;
                        ram_we      <= b_we;
                        lat_we      <= b_we;
                        b_ack       <= 1'b1;
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    state <= lat_we ? IDLE : READ_WAIT;
                end
                READ_WAIT: begin
                    if (gnt_port == PORT_A) begin
                        a_rdata  <= ram_data_out;
                        a_rvalid <= 1'b1;
                    end else begin
                        b_rdata  <= ram_data_out;
                        b_rvalid <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: randomized requesters on both ports of a round-robin and a
// fixed-priority arbiter, each with its own RAM, checked every cycle against a
// transaction-level model (busy-until time, grant rule, reference memory).
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n    [2];
    logic       req      [2][2];
    logic       we       [2][2];
    logic [11:0] addr    [2][2];
    logic [7:0] wdata    [2][2];
    logic       ack      [2][2];
    logic [7:0] rdata    [2][2];
    logic       rvalid   [2][2];
    logic [11:0] ram_addr[2];
    logic [7:0] ram_din  [2];
    logic       ram_we   [2];
    logic [7:0] ram_dout [2];

    logic [7:0] mem      [2][4096];
    logic [7:0] ref_mem  [2][4096];

    int n_checks = 0;
    int n_err    = 0;

    // model state for the instance currently under test
    int         cur;
    int         cyc;
    int         free_cyc;
    int         ack_cyc;
    int         ack_port;
    int         rv_cyc;
    int         rv_port;
    int         last_g;
    logic       m_we;
    logic [11:0] m_addr;
    logic [7:0] m_wdata;
    logic [7:0] rv_data;
    logic [7:0] exp_rdata[2];
    logic [11:0] exp_raddr;
    logic [7:0] exp_rdin;
    bit         gw[2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ram_arbiter #(
            .ADDR_WIDTH(12),
            .DATA_WIDTH(8),
            .FIXED_PRIO(g)
        ) u_dut (
            .clk         (clk),
            .reset_n     (rst_n[g]),
            .a_req       (req[g][0]),
            .a_we        (we[g][0]),
            .a_addr      (addr[g][0]),
            .a_wdata     (wdata[g][0]),
            .a_ack       (ack[g][0]),
            .a_rdata     (rdata[g][0]),
            .a_rvalid    (rvalid[g][0]),
            .b_req       (req[g][1]),
            .b_we        (we[g][1]),
            .b_addr      (addr[g][1]),
            .b_wdata     (wdata[g][1]),
            .b_ack       (ack[g][1]),
            .b_rdata     (rdata[g][1]),
            .b_rvalid    (rvalid[g][1]),
            .ram_addr    (ram_addr[g]),
            .ram_data_in (ram_din[g]),
            .ram_we      (ram_we[g]),
            .ram_data_out(ram_dout[g])
        );
    end

    // behavioural single-port RAMs, one per arbiter instance
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ram_we[i]) mem[i][ram_addr[i]] = ram_din[i];
            else           ram_dout[i] <= mem[i][ram_addr[i]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d cyc%0d: got %0h expected %0h", tag, cur, cyc, got, exp);
        end
    endtask

    function automatic logic [11:0] pick_addr();
        int r;
        r = $urandom_range(7, 0);
        case (r)
            0:       return 12'h000;
            1:       return 12'hFFF;
            2:       return 12'h123;
            3, 4, 5: return 12'($urandom_range(7, 0));
            default: return 12'($urandom);
        endcase
    endfunction

    task automatic new_req(input int i, input int p);
        req[i][p]   = 1'b1;
        we[i][p]    = ($urandom_range(99, 0) < 40);
        addr[i][p]  = pick_addr();
        wdata[i][p] = 8'($urandom);
    endtask

    task automatic clear_model();
        ack_cyc   = -1;
        rv_cyc    = -1;
        ack_port  = 0;
        rv_port   = 0;
        last_g    = 1;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        exp_raddr = '0;
        exp_rdin  = '0;
        gw[0]     = 1'b0;
        gw[1]     = 1'b0;
    endtask

    task automatic check_cycle(input int i);
        if (cyc == rv_cyc) exp_rdata[rv_port] = rv_data;
        if (cyc == ack_cyc) begin
            exp_raddr = m_addr;
            exp_rdin  = m_wdata;
        end
        chk("a_ack",    32'(ack[i][0]),    32'(cyc == ack_cyc && ack_port == 0));
        chk("b_ack",    32'(ack[i][1]),    32'(cyc == ack_cyc && ack_port == 1));
        chk("a_rvalid", 32'(rvalid[i][0]), 32'(cyc == rv_cyc && rv_port == 0));
        chk("b_rvalid", 32'(rvalid[i][1]), 32'(cyc == rv_cyc && rv_port == 1));
        chk("a_rdata",  32'(rdata[i][0]),  32'(exp_rdata[0]));
        chk("b_rdata",  32'(rdata[i][1]),  32'(exp_rdata[1]));
        chk("ram_we",   32'(ram_we[i]),    32'(cyc == ack_cyc && m_we));
        chk("ram_addr", 32'(ram_addr[i]),  32'(exp_raddr));
        chk("ram_data_in", 32'(ram_din[i]), 32'(exp_rdin));
    endtask

    // async reset asserted mid-cycle, released one cycle later
    task automatic do_reset(input int i);
        rst_n[i] = 1'b0;
        clear_model();
        #1;
        check_cycle(i);
        for (int p = 0; p < 2; p++) begin
            req[i][p] = 1'b0;
            we[i][p]  = 1'b0;
        end
        @(negedge clk);
        cyc++;
        rst_n[i] = 1'b1;
        free_cyc = cyc;
        check_cycle(i);
    endtask

    task automatic run(input int i, input int ncyc);
        int w;
        cur = i;
        cyc = 0;
        @(negedge clk);
        do_reset(i);
        repeat (ncyc) begin
            @(negedge clk);
            cyc++;
            check_cycle(i);
            if (cyc > free_cyc + 3 - 3 && $urandom_range(149, 0) == 0) begin
                do_reset(i);
            end else if (cyc == ack_cyc) begin
                // the granted access commits at the coming edge
                if (m_we) ref_mem[i][m_addr] = m_wdata;
                else      rv_data = ref_mem[i][m_addr];
            end
            // requesters: hold until ack, may withdraw before grant
            for (int p = 0; p < 2; p++) begin
                if (cyc == ack_cyc && ack_port == p) begin
                    gw[p] = 1'b0;
                    if ($urandom_range(99, 0) < 55) new_req(i, p);
                    else req[i][p] = 1'b0;
                end else if (!gw[p]) begin
                    if (req[i][p]) begin
                        if ($urandom_range(99, 0) < 8) req[i][p] = 1'b0;
                    end else if ($urandom_range(99, 0) < 30) begin
                        new_req(i, p);
                    end
                end
            end
            // reference arbitration: idle again once the previous access is done
            if (cyc >= free_cyc && (req[i][0] || req[i][1])) begin
                if (req[i][0] && req[i][1]) w = (i == 1) ? 0 : ((last_g == 0) ? 1 : 0);
                else                        w = req[i][0] ? 0 : 1;
                last_g   = w;
                gw[w]    = 1'b1;
                ack_cyc  = cyc + 1;
                ack_port = w;
                m_we     = we[i][w];
                m_addr   = addr[i][w];
                m_wdata  = wdata[i][w];
                if (m_we) begin
                    free_cyc = cyc + 2;
                end else begin
                    free_cyc = cyc + 3;
                    rv_cyc   = cyc + 3;
                    rv_port  = w;
                end
            end
        end
        for (int p = 0; p < 2; p++) req[i][p] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0;
            for (int p = 0; p < 2; p++) begin
                req[i][p]   = 1'b0;
                we[i][p]    = 1'b0;
                addr[i][p]  = '0;
                wdata[i][p] = '0;
            end
            for (int j = 0; j < 4096; j++) begin
                mem[i][j]     = 8'(j * 7 + i * 3);
                ref_mem[i][j] = 8'(j * 7 + i * 3);
            end
        end
        cur = 0;
        cyc = 0;
        free_cyc = 0;
        m_we = 1'b0;
        m_addr = '0;
        m_wdata = '0;
        rv_data = '0;
        clear_model();
        repeat (3) @(negedge clk);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        run(0, 4000);
        run(1, 4000);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
